// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller for the UART receiver. It detects the start bit and runs
// the per-bit edge counter that drives the data sampler. It takes the
// sampler's majority-voted bit once per bit period, deserializes the data
// LSB-first, and checks the optional parity bit and the stop bit.
//
// Ports:
//   CLK          oversampling clock, rising edge
//   RST          asynchronous active-low reset
//   RX_IN        synchronized serial line, idles high
//   PAR_EN       frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   prescale     oversampling ratio (8, 16 or 32)
//   sampled_bit  majority-voted bit from the data sampler
//   edge_cnt     edge index within the current bit, 0..prescale-1
//   data_samp_en sampler enable, high while a frame is in progress
//   P_DATA       last good received data word
//   data_valid   one-cycle pulse when P_DATA updates
//   par_err      one-cycle pulse, parity mismatch in the frame just ended
//   stp_err      one-cycle pulse, stop bit sampled as 0
module uart_rx_frame_ctrl #(
    parameter int PRESCALE_MAX = 32,
    parameter int DATA_WIDTH   = 8,
    localparam int W           = $clog2(PRESCALE_MAX) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [W-1:0]          prescale,
    input  logic                  sampled_bit,
    output logic [W-1:0]          edge_cnt,
    output logic                  data_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_nx;
    logic [W-1:0]          edge_nx;
    logic                  samp_en_nx;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
    logic [BW-1:0]         bit_cnt, bit_nx;
    logic [W-1:0]          ps_lat, ps_nx;
    logic                  par_en_lat, par_en_nx;
    logic                  par_typ_lat, par_typ_nx;
    logic                  par_flag, par_flag_nx;
    logic [DATA_WIDTH-1:0] p_data_nx;
    logic                  valid_nx, par_err_nx, stp_err_nx;
    logic                  eval;

    // Every piece of state, outputs included, is registered here so that
    // nothing the sampler or the parallel side sees comes from a comb path.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            data_samp_en <= 1'b0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            ps_lat       <= '0;
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            par_flag     <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            edge_cnt     <= edge_nx;
            data_samp_en <= samp_en_nx;
            shift_reg    <= shift_nx;
            bit_cnt      <= bit_nx;
            ps_lat       <= ps_nx;
            par_en_lat   <= par_en_nx;
            par_typ_lat  <= par_typ_nx;
            par_flag     <= par_flag_nx;
            P_DATA       <= p_data_nx;
            data_valid   <= valid_nx;
            par_err      <= par_err_nx;
            stp_err      <= stp_err_nx;
        end
    end

    // The last edge of each bit period is the only point where sampled_bit
    // is consumed; the counter wraps there.
    assign eval = (edge_cnt == ps_lat - W'(1));

    always_comb begin
        state_nx    = state;
        edge_nx     = edge_cnt;
        samp_en_nx  = data_samp_en;
        shift_nx    = shift_reg;
        bit_nx      = bit_cnt;
        ps_nx       = ps_lat;
        par_en_nx   = par_en_lat;
        par_typ_nx  = par_typ_lat;
        par_flag_nx = par_flag;
        p_data_nx   = P_DATA;
        valid_nx    = 1'b0;
        par_err_nx  = 1'b0;
        stp_err_nx  = 1'b0;

        if (state != IDLE) begin
            edge_nx    = eval ? '0 : edge_cnt + W'(1);
            samp_en_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                edge_nx    = '0;
                samp_en_nx = 1'b0;
                if (!RX_IN) begin
                    // Frame settings are frozen here so mid-frame changes
                    // on the inputs cannot corrupt the frame in progress.
                    state_nx    = START;
                    samp_en_nx  = 1'b1;
                    ps_nx       = prescale;
                    par_en_nx   = PAR_EN;
                    par_typ_nx  = PAR_TYP;
                    shift_nx    = '0;
                    bit_nx      = '0;
                    par_flag_nx = 1'b0;
                end
            end
            START: begin
                if (eval) begin
                    if (sampled_bit) begin
                        // Line came back high: treat as a glitch, stay silent.
                        state_nx   = IDLE;
                        edge_nx    = '0;
                        samp_en_nx = 1'b0;
                    end else begin
                        state_nx = DATA;
                        bit_nx   = '0;
                    end
                end
            end
            DATA: begin
                if (eval) begin
                    shift_nx = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    bit_nx   = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        state_nx = par_en_lat ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (eval) begin
                    if (sampled_bit != ((^shift_reg) ^ par_typ_lat)) begin
                        par_flag_nx = 1'b1;
                    end
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (eval) begin
                    state_nx   = IDLE;
                    edge_nx    = '0;
                    samp_en_nx = 1'b0;
                    if (!sampled_bit || par_flag) begin
                        par_err_nx = par_flag;
                        stp_err_nx = !sampled_bit;
                    end else begin
                        p_data_nx = shift_reg;
                        valid_nx  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx   = IDLE;
                edge_nx    = '0;
                samp_en_nx = 1'b0;
            end
        endcase
    end

endmodule
